// File: rtl/data_mem_responder_pkg.sv
// Shared encodings for the data-memory responder: access sizes and FSM states.
package data_mem_responder_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_BYTE = 2'b01;
  localparam logic [1:0] SIZE_HALF = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store byte enables/shifted data, misalign flag, load extraction.
module mem_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_sh,
  output logic        misalign,
  output logic [31:0] rdata_al
);

  logic [31:0] rshift;

  assign wdata_sh = wdata << {off, 3'b000};
  assign rshift   = rword >> {off, 3'b000};

  always_comb begin
    byte_en  = 4'b1111;
    misalign = 1'b0;
    rdata_al = rshift;
    case (size)
      SIZE_BYTE: begin
        byte_en  = 4'b0001 << off;
        rdata_al = {24'h0, rshift[7:0]};
      end
      SIZE_HALF: begin
        byte_en  = 4'b0011 << off;
        misalign = off[0];
        rdata_al = {16'h0, rshift[15:0]};
      end
      default: begin
        // size 11 behaves exactly like a word access
        misalign = (off != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: valid/ready accept, fixed-latency commit, one-cycle response strobe.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;

  logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

  logic [29:0]   word_idx;
  logic [AW-1:0] ram_idx;
  logic          in_range;
  logic          commit;
  logic          acc_err;
  logic [3:0]    byte_en;
  logic [31:0]   wdata_sh;
  logic          misalign;
  logic [31:0]   rword;
  logic [31:0]   rdata_al;

  assign word_idx  = addr_q[31:2];
  assign ram_idx   = addr_q[AW+1:2];
  assign in_range  = (word_idx >> AW) == '0;
  assign rword     = mem[ram_idx];
  assign commit    = (state == ST_WAIT) && (cnt == '0);
  assign acc_err   = misalign || !in_range;
  assign req_ready = (state == ST_IDLE);

  mem_lane_align u_align (
    .size     (size_q),
    .off      (addr_q[1:0]),
    .wdata    (wdata_q),
    .rword    (rword),
    .byte_en  (byte_en),
    .wdata_sh (wdata_sh),
    .misalign (misalign),
    .rdata_al (rdata_al)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= SIZE_WORD;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          resp_valid <= 1'b0;
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            size_q  <= req_size;
            cnt     <= 4'(LATENCY - 1);
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (commit) begin
            resp_valid <= 1'b1;
            resp_err   <= acc_err;
            resp_rdata <= (acc_err || we_q) ? '0 : rdata_al;
            state      <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          resp_valid <= 1'b0;
          state      <= ST_IDLE;
        end
        default: begin
          resp_valid <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

  // RAM is not reset; a reset before the commit edge leaves state out of WAIT, so no write
  always_ff @(posedge clk) begin
    if (commit && we_q && !acc_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[ram_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench against a byte-addressed reference memory.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks   = 0;
  int failures = 0;

  logic [7:0] model_bytes [4*DEPTH];

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_size   (req_size),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    if (size == 2'b01) return 1;
    if (size == 2'b10) return 2;
    return 4;
  endfunction

  // One full transaction from IDLE; compares latency, rdata and err to the byte model.
  task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [1:0] size);
    int          n;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          cyc;
    n         = nbytes(size);
    exp_err   = ((addr % n) != 0) || ((addr >> 2) >= DEPTH);
    exp_rdata = '0;
    if (!exp_err && !we)
      for (int b = 0; b < n; b++) exp_rdata[8*b +: 8] = model_bytes[int'(addr) + b];

    @(negedge clk);
    check({tag, ".ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_size = size;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    cyc = 1;
    while (!resp_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ".latency"}, cyc, LAT + 1);
    check({tag, ".err"}, {31'b0, resp_err}, {31'b0, exp_err});
    check({tag, ".rdata"}, resp_rdata, exp_rdata);
    if (!exp_err && we)
      for (int b = 0; b < n; b++) model_bytes[int'(addr) + b] = wdata[8*b +: 8];
    @(negedge clk);
    check({tag, ".strobe_1cyc"}, {31'b0, resp_valid}, 32'd0);
  endtask

  task automatic load_word_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    int cyc;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr; req_wdata = '0; req_size = 2'b00;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (!resp_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ".seen"}, {31'b0, resp_valid}, 32'd1);
    check(tag, resp_rdata, exp);
    @(negedge clk);
  endtask

  initial begin
    int accepts;
    int seen_resp;
    logic [31:0] a;
    logic [1:0]  s;

    for (int i = 0; i < 4*DEPTH; i++) model_bytes[i] = 8'h00;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_size = '0;
    #23;
    check("rst.resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst.resp_rdata", resp_rdata, 32'd0);
    check("rst.resp_err",   {31'b0, resp_err}, 32'd0);
    check("rst.req_ready",  {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    txn("t1.st_word", 1'b1, 32'h10, 32'hDEADBEEF, 2'b00);
    txn("t1.ld_word", 1'b0, 32'h10, 32'h0, 2'b00);
    load_word_check("t1.const", 32'h10, 32'hDEADBEEF);
    txn("t2.st_byte", 1'b1, 32'h13, 32'h000000AB, 2'b01);
    load_word_check("t2.word", 32'h10, 32'hABADBEEF);
    txn("t2.ld_byte", 1'b0, 32'h13, 32'h0, 2'b01);
    txn("t3.st_half", 1'b1, 32'h12, 32'h00001234, 2'b10);
    load_word_check("t3.word", 32'h10, 32'h1234BEEF);
    txn("t3.ld_half", 1'b0, 32'h12, 32'h0, 2'b10);
    txn("t4.ld_mis", 1'b0, 32'h11, 32'h0, 2'b00);
    txn("t4.st_mis", 1'b1, 32'h13, 32'hFFFFFFFF, 2'b10);
    load_word_check("t4.unchanged", 32'h10, 32'h1234BEEF);
    txn("t5.st_oor", 1'b1, 4*DEPTH, 32'hCAFEF00D, 2'b00);
    load_word_check("t5.word0", 32'h0, 32'h0);
    txn("t5.st_top", 1'b1, 4*DEPTH - 4, 32'h0BADCAFE, 2'b11);
    txn("t5.ld_top", 1'b0, 4*DEPTH - 4, 32'h0, 2'b00);

    for (int k = 0; k < 150; k++) begin
      a = $urandom_range(0, 63);
      if ($urandom_range(0, 7) == 0) a = $urandom_range(4*DEPTH - 8, 4*DEPTH + 8);
      if ($urandom_range(0, 15) == 0) a = $urandom;
      s = 2'($urandom_range(0, 3));
      txn("rand", 1'($urandom_range(0, 1)), a, $urandom, s);
    end

    // Continuous request: exactly one accept per LAT+2 cycles
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 2'b00;
    accepts = 0;
    for (int c = 0; c < 4*(LAT + 2); c++) begin
      if (req_ready) accepts++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("t6.accepts", accepts, 4);
    for (int c = 0; c < 20 && !req_ready; c++) @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("t6.idle", {31'b0, req_ready}, 32'd1);

    // Reset one cycle after accepting a store: dropped, no write, no response
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h55AA55AA; req_size = 2'b00;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    seen_resp = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (resp_valid) seen_resp++;
    end
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (resp_valid) seen_resp++;
    end
    check("t6.rst_no_resp", seen_resp, 0);
    check("t6.rst_ready", {31'b0, req_ready}, 32'd1);
    txn("t6.rst_unchanged", 1'b0, 32'h10, 32'h0, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
